// File: rtl/rv32_dmem_responder_pkg.sv
// Shared definitions for the RV32 data-memory responder: core constants,
// peripheral address map, UART state encoding and byte-merge helpers.
package rv32_dmem_responder_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] MTIME_LO_ADDR    = 32'h1000_0000;
  localparam logic [31:0] MTIME_HI_ADDR    = 32'h1000_0004;
  localparam logic [31:0] MTIMECMP_LO_ADDR = 32'h1000_0008;
  localparam logic [31:0] MTIMECMP_HI_ADDR = 32'h1000_000C;
  localparam logic [31:0] UART_TXDATA_ADDR = 32'h1000_0010;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0014;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  typedef struct packed {
    logic             en;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [3:0]       mask;
  } dmem_req_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = mask[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
    return res;
  endfunction

  // Word-granular match; byte offset bits are masked off.
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] base);
    return (addr & ~32'h3) == base;
  endfunction

endpackage

// File: rtl/rv32_uart_tx.sv
// 8N1 serial transmitter; accepts a byte only while idle, so frames are
// always separated by at least one idle cycle.
module rv32_uart_tx
  import rv32_dmem_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          bit_done;

  assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        UART_IDLE: if (start) begin
          state_q <= UART_START;
          shift_q <= data;
          cnt_q   <= '0;
          tx_q    <= 1'b0;
        end
        UART_START: if (bit_done) begin
          state_q <= UART_DATA;
          cnt_q   <= '0;
          bit_q   <= '0;
          tx_q    <= shift_q[0];
        end else cnt_q <= cnt_q + 1'b1;
        UART_DATA: if (bit_done) begin
          cnt_q <= '0;
          if (bit_q == 3'd7) begin
            state_q <= UART_STOP;
            tx_q    <= 1'b1;
          end else begin
            // Next bit sits at [1] before the shift takes effect.
            bit_q   <= bit_q + 3'd1;
            tx_q    <= shift_q[1];
            shift_q <= shift_q >> 1;
          end
        end else cnt_q <= cnt_q + 1'b1;
        UART_STOP: if (bit_done) begin
          state_q <= UART_IDLE;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= UART_IDLE;
      endcase
    end
  end

  assign busy = (state_q != UART_IDLE);
  assign tx   = tx_q;

endmodule

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder for a single-cycle RV32 core: word RAM, 64-bit
// machine timer with compare interrupt, and a UART transmitter.
module rv32_dmem_responder
  import rv32_dmem_responder_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wr_mask_i,
  output logic [31:0] rdata_o,
  output logic        timer_irq_o,
  output logic        uart_tx_o
);
  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  dmem_req_t   req;
  logic [31:0] ram_q [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic        timer_irq_q;
  logic        wr, ram_hit, uart_busy, uart_start;
  logic        sel_mt_lo, sel_mt_hi, sel_cmp_lo, sel_cmp_hi, sel_txd, sel_stat;

  assign req        = '{en: mem_enable_i, addr: addr_i, wdata: wdata_i, mask: wr_mask_i};
  assign wr         = req.en && (req.mask != 4'b0);
  assign ram_hit    = req.addr < RAM_BYTES;
  assign ram_idx    = req.addr[AW+1:2];
  assign sel_mt_lo  = word_match(req.addr, MTIME_LO_ADDR);
  assign sel_mt_hi  = word_match(req.addr, MTIME_HI_ADDR);
  assign sel_cmp_lo = word_match(req.addr, MTIMECMP_LO_ADDR);
  assign sel_cmp_hi = word_match(req.addr, MTIMECMP_HI_ADDR);
  assign sel_txd    = word_match(req.addr, UART_TXDATA_ADDR);
  assign sel_stat   = word_match(req.addr, UART_STATUS_ADDR);
  assign uart_start = req.en && sel_txd && req.mask[0];

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr && ram_hit)
      ram_q[ram_idx] <= byte_merge(ram_q[ram_idx], req.wdata, req.mask);
  end

  // A write to either mtime half replaces the increment for that cycle.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (wr && sel_mt_lo)
      mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], req.wdata, req.mask)};
    if (wr && sel_mt_hi)
      mtime_d = {byte_merge(mtime_q[63:32], req.wdata, req.mask), mtime_q[31:0]};
    if (wr && sel_cmp_lo)
      mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], req.wdata, req.mask);
    if (wr && sel_cmp_hi)
      mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], req.wdata, req.mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      timer_irq_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  rv32_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (uart_start),
    .data    (req.wdata[7:0]),
    .busy    (uart_busy),
    .tx      (uart_tx_o)
  );

  always_comb begin
    rdata_o = '0;
    if (ram_hit)         rdata_o = ram_q[ram_idx];
    else if (sel_mt_lo)  rdata_o = mtime_q[31:0];
    else if (sel_mt_hi)  rdata_o = mtime_q[63:32];
    else if (sel_cmp_lo) rdata_o = mtimecmp_q[31:0];
    else if (sel_cmp_hi) rdata_o = mtimecmp_q[63:32];
    else if (sel_stat)   rdata_o = {31'b0, uart_busy};
  end

  assign timer_irq_o = timer_irq_q;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed bench for rv32_dmem_responder: table of single-access vectors
// followed by timer, mtime wrap, UART frame and mid-frame reset sequences.
module tb_rv32_dmem_responder;
  localparam logic [31:0] A_MT_LO  = 32'h1000_0000;
  localparam logic [31:0] A_MT_HI  = 32'h1000_0004;
  localparam logic [31:0] A_CMP_LO = 32'h1000_0008;
  localparam logic [31:0] A_CMP_HI = 32'h1000_000C;
  localparam logic [31:0] A_TXD    = 32'h1000_0010;
  localparam logic [31:0] A_STAT   = 32'h1000_0014;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_enable_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic [3:0]  wr_mask_i;
  logic        timer_irq_o, uart_tx_o;

  int nchecks = 0;
  int nerr    = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  rv32_dmem_responder #(.RAM_WORDS(64), .CLKS_PER_BIT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_enable_i (mem_enable_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .wr_mask_i    (wr_mask_i),
    .rdata_o      (rdata_o),
    .timer_irq_o  (timer_irq_o),
    .uart_tx_o    (uart_tx_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a;
    #1;
    check(name, rdata_o, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_enable_i = 1'b1;
    addr_i       = a;
    wdata_i      = d;
    wr_mask_i    = m;
    @(posedge clk);
    #1;
    mem_enable_i = 1'b0;
    wr_mask_i    = 4'h0;
  endtask

  initial begin
    logic [7:0] frame;
    logic       exp_tx;

    vecs[0]  = '{1'b1, 32'h40,        32'hDEADBEEF, 4'hF, 32'h40,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 32'h40,        32'h00005500, 4'h2, 32'h40,        32'hDEAD55EF};
    vecs[2]  = '{1'b1, 32'h42,        32'h00000000, 4'h0, 32'h40,        32'hDEAD55EF};
    vecs[3]  = '{1'b1, 32'h44,        32'h00000000, 4'hF, 32'h44,        32'h00000000};
    vecs[4]  = '{1'b1, 32'h44,        32'h12345678, 4'h9, 32'h47,        32'h12000078};
    vecs[5]  = '{1'b1, 32'h100,       32'hAABBCCDD, 4'hF, 32'h100,       32'h00000000};
    vecs[6]  = '{1'b1, 32'h20000040,  32'hFFFFFFFF, 4'hF, 32'h40,        32'hDEAD55EF};
    vecs[7]  = '{1'b1, A_STAT,        32'hFFFFFFFF, 4'hF, A_STAT,        32'h00000000};
    vecs[8]  = '{1'b1, A_TXD,         32'h000000AA, 4'h0, A_TXD,         32'h00000000};
    vecs[9]  = '{1'b0, 32'h0,         32'h00000000, 4'h0, A_STAT,        32'h00000000};
    vecs[10] = '{1'b1, A_CMP_LO,      32'h11223344, 4'hF, A_CMP_LO,      32'h11223344};
    vecs[11] = '{1'b1, A_CMP_LO,      32'h00AA0000, 4'h4, A_CMP_LO,      32'h11AA3344};
    vecs[12] = '{1'b0, 32'h0,         32'h00000000, 4'h0, A_CMP_HI,      32'hFFFFFFFF};

    reset_n = 1'b0; mem_enable_i = 1'b0; addr_i = '0; wdata_i = '0; wr_mask_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", {31'b0, uart_tx_o}, 32'd1);
    check("rst_irq", {31'b0, timer_irq_o}, 32'd0);
    rd_check("rst_mtime_lo", A_MT_LO, 32'h0);
    rd_check("rst_cmp_lo", A_CMP_LO, 32'hFFFFFFFF);
    rd_check("rst_cmp_hi", A_CMP_HI, 32'hFFFFFFFF);
    rd_check("rst_status", A_STAT, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      mem_enable_i = vecs[i].we;
      addr_i       = vecs[i].addr;
      wdata_i      = vecs[i].wdata;
      wr_mask_i    = vecs[i].mask;
      @(posedge clk);
      #1;
      mem_enable_i = 1'b0;
      wr_mask_i    = 4'h0;
      rd_check($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
      check($sformatf("vec%0d_tx_idle", i), {31'b0, uart_tx_o}, 32'd1);
    end

    // Timer compare: mtime restarted at 0, mtimecmp = 20.
    wr(A_MT_HI, 32'h0, 4'hF);
    wr(A_MT_LO, 32'h0, 4'hF);
    rd_check("mtime_load_no_inc", A_MT_LO, 32'h0);
    wr(A_CMP_HI, 32'h0, 4'hF);
    wr(A_CMP_LO, 32'd20, 4'hF);
    for (int k = 3; k <= 24; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("irq_k%0d", k), {31'b0, timer_irq_o}, {31'b0, k >= 21});
      rd_check($sformatf("mtime_k%0d", k), A_MT_LO, 32'(k));
    end

    // 64-bit wrap and partial-byte mtime load.
    wr(A_MT_HI, 32'hFFFFFFFF, 4'hF);
    wr(A_MT_LO, 32'hFFFFFFFE, 4'hF);
    rd_check("wrap_pre_lo", A_MT_LO, 32'hFFFFFFFE);
    rd_check("wrap_pre_hi", A_MT_HI, 32'hFFFFFFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_check("wrap_lo", A_MT_LO, 32'h0);
    rd_check("wrap_hi", A_MT_HI, 32'h0);
    wr(A_MT_LO, 32'h0000CD00, 4'h2);
    rd_check("mtime_byte_lo", A_MT_LO, 32'h0000CD00);
    rd_check("mtime_byte_hi", A_MT_HI, 32'h0);

    // UART frame 0xA5 with dropped writes mid-frame and on the final STOP cycle.
    frame = 8'hA5;
    wr(A_TXD, 32'h000000A5, 4'h1);
    for (int k = 0; k < 44; k++) begin
      mem_enable_i = 1'b0;
      wr_mask_i    = 4'h0;
      if (k < 4)       exp_tx = 1'b0;
      else if (k < 36) exp_tx = frame[(k - 4) / 4];
      else             exp_tx = 1'b1;
      check($sformatf("uart_tx_k%0d", k), {31'b0, uart_tx_o}, {31'b0, exp_tx});
      rd_check($sformatf("uart_busy_k%0d", k), A_STAT, {31'b0, k < 40});
      if (k == 10 || k == 39) begin
        mem_enable_i = 1'b1;
        addr_i       = A_TXD;
        wdata_i      = (k == 10) ? 32'h3C : 32'h5A;
        wr_mask_i    = 4'h1;
      end
      @(posedge clk);
      #1;
    end
    mem_enable_i = 1'b0;
    wr_mask_i    = 4'h0;

    // Reset during DATA aborts the frame immediately.
    wr(A_TXD, 32'h00000000, 4'h1);
    repeat (10) begin @(posedge clk); #1; end
    check("mid_frame_tx_low", {31'b0, uart_tx_o}, 32'd0);
    check("irq_before_reset", {31'b0, timer_irq_o}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_tx", {31'b0, uart_tx_o}, 32'd1);
    check("abort_irq", {31'b0, timer_irq_o}, 32'd0);
    rd_check("abort_status", A_STAT, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_tx", {31'b0, uart_tx_o}, 32'd1);
    rd_check("post_rst_status", A_STAT, 32'h0);
    rd_check("post_rst_cmp_hi", A_CMP_HI, 32'hFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/rv32_dmem_responder.md
RV32_DMEM_RESPONDER -- requirements
Module: rv32_dmem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, data RAM depth in 32-bit words.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, UART bit period in clk cycles (minimum 2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port mem_enable_i  input  1  access strobe from core.
REQ-006 SHALL have port addr_i  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have port wdata_i  input  32  write data.
REQ-008 SHALL have port wr_mask_i  input  4  byte-write mask; 0 with mem_enable_i means read.
REQ-009 SHALL have port rdata_o  output  32  read data, combinational from addr_i.
REQ-010 SHALL have port timer_irq_o  output  1  registered machine-timer interrupt.
REQ-011 SHALL have port uart_tx_o  output  1  serial 8N1 transmit line, idle high.

Function
REQ-012 SHALL decode: 0x0000_0000..RAM_WORDS*4-1 RAM; 0x1000_0000 MTIME_LO; 0x1000_0004 MTIME_HI; 0x1000_0008 MTIMECMP_LO; 0x1000_000C MTIMECMP_HI; 0x1000_0010 UART_TXDATA; 0x1000_0014 UART_STATUS (bit0 busy, others 0).
REQ-013 SHALL return rdata_o in the same cycle as addr_i (zero latency) for read-only use by a single-cycle core; unmapped addresses and UART_TXDATA read 0.
REQ-014 SHALL write only when mem_enable_i=1, on the rising clk edge; byte lane i (bits 8i+7:8i) written iff wr_mask_i[i]=1, for RAM and MTIME/MTIMECMP alike.
REQ-015 SHALL ignore writes to unmapped addresses and UART_STATUS without side effect.
REQ-016 SHALL increment the 64-bit mtime by 1 every cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0; carry from LO into HI in the same cycle.
REQ-017 SHALL, on a write to MTIME_LO or MTIME_HI, load the written bytes instead of incrementing that cycle (unwritten bytes hold current value, no increment).
REQ-018 SHALL register timer_irq_o <= (mtime >= mtimecmp) unsigned 64-bit, one cycle latency.
REQ-019 SHALL implement UART FSM states IDLE, START, DATA, STOP; busy=1 in all states except IDLE.
REQ-020 SHALL start transmission from IDLE on a write to UART_TXDATA with wr_mask_i[0]=1, latching wdata_i[7:0]; next state START.
REQ-021 SHALL drive uart_tx_o 0 in START, data bit n (LSB first, n=0..7) in DATA, 1 in STOP and IDLE, each state/bit held exactly CLKS_PER_BIT cycles.
REQ-022 SHALL return to IDLE after STOP; a write accepted on the same edge IDLE is re-entered is allowed only from IDLE, i.e. back-to-back frames are separated by >=1 cycle of IDLE.
REQ-023 SHALL silently drop UART_TXDATA writes while busy=1.

Reset
REQ-024 SHALL, while reset_n=0, force mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, timer_irq_o=0, UART state IDLE, bit/cycle counters 0, uart_tx_o=1.
REQ-025 SHALL abort any in-flight UART frame on reset assertion, tx line returning high immediately.
REQ-026 SHALL not reset RAM contents (undefined until written).

Structure
REQ-027 SHALL place address map constants and UART state encodings in shared DEFINITIONS include, alongside existing core constants.
REQ-028 SHALL implement UART transmitter as one sub-module rv32_uart_tx (ports clk, reset_n, start, data[7:0], busy, tx).
REQ-029 SHALL keep RAM, timer and decode in the top module; no other sub-modules.

Verification
REQ-030 RAM: write 0xDEADBEEF to 0x40 mask 0xF, then mask 0x2 data 0x0000_5500 -> read 0x40 returns 0xDEAD55EF same cycle.
REQ-031 Timer: after reset write MTIMECMP_HI=0, MTIMECMP_LO=20 -> timer_irq_o rises the cycle after mtime reaches 20, stays high.
REQ-032 Wrap: write MTIME_HI=0xFFFFFFFF, MTIME_LO=0xFFFFFFFE -> two cycles later MTIME_HI/LO read 0/0.
REQ-033 UART: CLKS_PER_BIT=4, write 0xA5 -> uart_tx_o 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1; STATUS busy=1 for 40 cycles.
REQ-034 UART busy: write 0x3C during frame of 0xA5 -> ignored, only 0xA5 frame observed.
REQ-035 Reset mid-frame: assert reset_n=0 during DATA -> uart_tx_o=1, STATUS=0, timer_irq_o=0 immediately.
